// File: rtl/myhardware_onchip_mem_master_if.sv
// Command/status and Avalon-MM bus bundle for the on-chip memory master engine.
// Compare outputs exist only when MEM_MASTER_COMPARE_EN is defined.
interface myhardware_onchip_mem_master_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W:0]   cmd_len;
   logic [DATA_W-1:0] cmd_pattern;
   logic              cmd_incr;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] result_sum;
   logic [ADDR_W-1:0] avm_address;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic              avm_chipselect;
   logic              avm_write;
   logic [DATA_W-1:0] avm_writedata;
   logic              avm_clken;
   logic [DATA_W-1:0] avm_readdata;
`ifdef MEM_MASTER_COMPARE_EN
   logic [ADDR_W:0]   mismatch_cnt;
   logic [ADDR_W-1:0] first_bad_addr;
   logic              first_bad_valid;
`endif

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_pattern, cmd_incr, avm_readdata,
      output cmd_ready, busy, done, err, result_sum,
      output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken
`ifdef MEM_MASTER_COMPARE_EN
      , output mismatch_cnt, first_bad_addr, first_bad_valid
`endif
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_pattern, cmd_incr, avm_readdata,
      input  cmd_ready, busy, done, err, result_sum,
      input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken
`ifdef MEM_MASTER_COMPARE_EN
      , input mismatch_cnt, first_bad_addr, first_bad_valid
`endif
   );
endinterface

// File: rtl/myhardware_onchip_mem_master.sv
// Avalon-MM fill/readback engine for the 5000x32 on-chip RAM s1 port.
// Optional readback compare against the fill pattern: define MEM_MASTER_COMPARE_EN.
module myhardware_onchip_mem_master #(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 5000,
   parameter int READ_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   myhardware_onchip_mem_master_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_FIN} state_t;

   localparam logic [ADDR_W+1:0] LP_DEPTH = (ADDR_W+2)'(DEPTH);

   state_t                  r_state;
   logic                    r_ready;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;
   logic                    r_cs;
   logic                    r_wr;
   logic [ADDR_W-1:0]       r_addr;
   logic [DATA_W-1:0]       r_wdata;
   logic [DATA_W-1:0]       r_sum;
   logic [DATA_W-1:0]       r_step;
   logic [ADDR_W:0]         r_len;
   logic [ADDR_W:0]         r_idx;
   logic [READ_LATENCY-1:0] r_vld;

   logic                    w_accept;
   logic [ADDR_W+1:0]       w_end;
   logic                    w_last;
   logic                    w_issue;
   logic                    w_emerge;
   logic [READ_LATENCY-1:0] w_vld_nxt;

   assign w_accept  = bus.cmd_valid && r_ready;
   assign w_end     = {2'b00, bus.cmd_addr} + {1'b0, bus.cmd_len};
   assign w_last    = (r_idx == r_len - 1'b1);
   assign w_issue   = r_cs && !r_wr;
   assign w_emerge  = r_vld[READ_LATENCY-1];
   // Bit 0 marks a read issued this cycle; the top bit is the word whose data is on avm_readdata now.
   assign w_vld_nxt = (r_vld << 1) | READ_LATENCY'(w_issue);

`ifdef MEM_MASTER_COMPARE_EN
   logic [ADDR_W-1:0] r_start;
   logic [ADDR_W:0]   r_rcnt;
   logic [DATA_W-1:0] r_exp;
   logic [ADDR_W:0]   r_mcnt;
   logic [ADDR_W-1:0] r_fba;
   logic              r_fbv;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_start <= '0;
         r_rcnt  <= '0;
         r_exp   <= '0;
         r_mcnt  <= '0;
         r_fba   <= '0;
         r_fbv   <= 1'b0;
      end else if (r_state == S_IDLE && w_accept) begin
         r_start <= bus.cmd_addr;
         r_rcnt  <= '0;
         r_exp   <= bus.cmd_pattern;
         r_mcnt  <= '0;
         r_fba   <= '0;
         r_fbv   <= 1'b0;
      end else if (w_emerge) begin
         r_rcnt <= r_rcnt + 1'b1;
         r_exp  <= r_exp + r_step;
         if (bus.avm_readdata != r_exp) begin
            if (r_mcnt != '1) r_mcnt <= r_mcnt + 1'b1;
            if (!r_fbv) begin
               r_fbv <= 1'b1;
               r_fba <= r_start + r_rcnt[ADDR_W-1:0];
            end
         end
      end
   end

   assign bus.mismatch_cnt    = r_mcnt;
   assign bus.first_bad_addr  = r_fba;
   assign bus.first_bad_valid = r_fbv;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_cs    <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_sum   <= '0;
         r_step  <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_vld   <= '0;
      end else begin
         r_vld <= w_vld_nxt;
         if (w_emerge) r_sum <= r_sum + bus.avm_readdata;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_sum   <= '0;
                  r_len   <= bus.cmd_len;
                  r_idx   <= '0;
                  r_step  <= bus.cmd_incr ? DATA_W'(1) : '0;
                  if (bus.cmd_len == '0) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                     r_err   <= 1'b0;
                  end else if (w_end > LP_DEPTH) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= bus.cmd_write ? S_WR : S_RD;
                     r_cs    <= 1'b1;
                     r_wr    <= bus.cmd_write;
                     r_addr  <= bus.cmd_addr;
                     if (bus.cmd_write) r_wdata <= bus.cmd_pattern;
                  end
               end
            end
            S_WR, S_RD: begin
               if (w_last) begin
                  r_cs <= 1'b0;
                  r_wr <= 1'b0;
                  if (r_state == S_WR) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else begin
                  r_idx  <= r_idx + 1'b1;
                  r_addr <= r_addr + 1'b1;
                  if (r_state == S_WR) r_wdata <= r_wdata + r_step;
               end
            end
            S_DRAIN: begin
               if (w_vld_nxt == '0) begin
                  r_state <= S_FIN;
                  r_done  <= 1'b1;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready      = r_ready;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.err            = r_err;
   assign bus.result_sum     = r_sum;
   assign bus.avm_address    = r_addr;
   assign bus.avm_byteenable = '1;
   assign bus.avm_chipselect = r_cs;
   assign bus.avm_write      = r_wr;
   assign bus.avm_writedata  = r_wdata;
   assign bus.avm_clken      = 1'b1;
endmodule

// File: tb/tb_myhardware_onchip_mem_master.sv
// Bench for myhardware_onchip_mem_master: RAM model, reference memory and directed plus random commands.
module tb_myhardware_onchip_mem_master;
   localparam int AW    = 13;
   localparam int DW    = 32;
   localparam int DEPTH = 5000;
   localparam int RL    = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   myhardware_onchip_mem_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   myhardware_onchip_mem_master #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(RL)
   ) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // RAM: registered address, unregistered data out
   bit [DW-1:0] mem [DEPTH];
   bit [AW-1:0] ram_qa;
   always @(posedge clk) begin
      if (bus.avm_chipselect && bus.avm_clken) begin
         if (bus.avm_write) mem[bus.avm_address] <= bus.avm_writedata;
         ram_qa <= bus.avm_address;
      end
   end
   assign bus.avm_readdata = mem[ram_qa];

   bit [DW-1:0] ref_mem [DEPTH];

   // bus/status monitor, sampled mid-cycle
   int          ncyc = 0;
   bit          mon_en = 1'b0;
   int          cs_cnt, done_cnt, done_idx, first_cs, last_cs;
   logic        done_err;
   logic [DW-1:0] done_sum;
   logic [AW-1:0] aq[$];
   logic [DW-1:0] dq[$];
   logic          wq[$];
`ifdef MEM_MASTER_COMPARE_EN
   logic [AW:0]   done_mcnt;
   logic [AW-1:0] done_fba;
   logic          done_fbv;
`endif

   always @(negedge clk) begin
      ncyc = ncyc + 1;
      if (mon_en) begin
         if (bus.avm_chipselect === 1'b1) begin
            if (cs_cnt == 0) first_cs = ncyc;
            last_cs = ncyc;
            cs_cnt = cs_cnt + 1;
            aq.push_back(bus.avm_address);
            dq.push_back(bus.avm_writedata);
            wq.push_back(bus.avm_write);
         end
         if (bus.done === 1'b1) begin
            if (done_cnt == 0) begin
               done_idx = ncyc;
               done_err = bus.err;
               done_sum = bus.result_sum;
`ifdef MEM_MASTER_COMPARE_EN
               done_mcnt = bus.mismatch_cnt;
               done_fba  = bus.first_bad_addr;
               done_fbv  = bus.first_bad_valid;
`endif
            end
            done_cnt = done_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mon_clear();
      cs_cnt = 0; done_cnt = 0; done_idx = 0; first_cs = 0; last_cs = 0;
      aq.delete(); dq.delete(); wq.delete();
      mon_en = 1'b1;
   endtask

   // Presents a command and returns the monitor cycle index of the accept cycle.
   task automatic accept_cmd(input bit wr, input int addr, input int len, input logic [31:0] pat,
                             input bit incr, output int acc);
      int k;
      mon_clear();
      bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = AW'(addr);
      bus.cmd_len = (AW+1)'(len); bus.cmd_pattern = pat; bus.cmd_incr = incr;
      k = 0;
      while (bus.cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); #1; k++; end
      chk("cmd_ready_before_accept", bus.cmd_ready, 1'b1);
      @(posedge clk);
      acc = ncyc;
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom); bus.cmd_addr = AW'($urandom);
      bus.cmd_len = (AW+1)'($urandom); bus.cmd_pattern = $urandom; bus.cmd_incr = 1'($urandom);
   endtask

   task automatic run_cmd(input bit wr, input int addr, input int len, input logic [31:0] pat,
                          input bit incr);
      int acc, exp_cs, nbad;
      bit exp_err;
      logic [31:0] exp_sum;
      exp_err = (len != 0) && (addr + len > DEPTH);
      exp_cs  = (len == 0 || exp_err) ? 0 : len;
      accept_cmd(wr, addr, len, pat, incr, acc);
      for (int k = 0; k < len + 40 && done_cnt == 0; k++) begin @(negedge clk); #1; end
      chk("done_seen", done_cnt != 0, 1'b1);
      if (done_cnt == 0) begin mon_en = 1'b0; return; end
      @(negedge clk); #1;
      chk("done_low_after", bus.done, 1'b0);
      chk("ready_after", bus.cmd_ready, 1'b1);
      chk("busy_after", bus.busy, 1'b0);
      repeat (2) begin @(negedge clk); #1; end
      mon_en = 1'b0;
      chk("done_width", done_cnt, 1);
      chk("err", done_err, exp_err);
      chk("cs_cycles", cs_cnt, exp_cs);
      if (exp_cs == 0) begin
         chk("early_done", (done_idx - acc) <= 2, 1'b1);
         chk("sum_nobus", done_sum, 32'h0);
      end else if (wr) begin
         chk("wr_consecutive", last_cs - first_cs + 1, len);
         chk("wr_done_lat", done_idx - last_cs, 1);
         nbad = 0;
         for (int i = 0; i < exp_cs && i < aq.size(); i++) begin
            if (wq[i] !== 1'b1 || aq[i] !== AW'(addr + i) ||
                dq[i] !== pat + (incr ? 32'(i) : 32'h0)) nbad++;
         end
         chk("wr_words", nbad, 0);
         chk("wr_sum", done_sum, 32'h0);
         for (int i = 0; i < len; i++) ref_mem[addr + i] = pat + (incr ? 32'(i) : 32'h0);
      end else begin
         exp_sum = '0;
         nbad = 0;
         for (int i = 0; i < len; i++) exp_sum = exp_sum + ref_mem[addr + i];
         for (int i = 0; i < exp_cs && i < aq.size(); i++)
            if (wq[i] !== 1'b0 || aq[i] !== AW'(addr + i)) nbad++;
         chk("rd_addrs", nbad, 0);
         chk("rd_consecutive", last_cs - first_cs + 1, len);
         chk("rd_done_lat", done_idx - last_cs, RL + 1);
         chk("rd_sum", done_sum, exp_sum);
         chk("rd_sum_held", bus.result_sum, exp_sum);
`ifdef MEM_MASTER_COMPARE_EN
         begin
            int mc; logic [AW-1:0] fba; bit fbv;
            mc = 0; fba = '0; fbv = 1'b0;
            for (int i = 0; i < len; i++) begin
               if (ref_mem[addr + i] != pat + (incr ? 32'(i) : 32'h0)) begin
                  if (!fbv) begin fbv = 1'b1; fba = AW'(addr + i); end
                  mc++;
               end
            end
            chk("mismatch_cnt", done_mcnt, (AW+1)'(mc));
            chk("first_bad_valid", done_fbv, fbv);
            if (fbv) chk("first_bad_addr", done_fba, fba);
         end
`endif
      end
   endtask

   initial begin
      int acc, k, sel, len, addr;
      logic [31:0] p;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
      bus.cmd_len = '0; bus.cmd_pattern = '0; bus.cmd_incr = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", bus.cmd_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_sum", bus.result_sum, 32'h0);
      chk("rst_cs", bus.avm_chipselect, 1'b0);
      chk("rst_write", bus.avm_write, 1'b0);
      chk("rst_addr", bus.avm_address, 13'h0);
      chk("rst_wdata", bus.avm_writedata, 32'h0);
      chk("rst_be", bus.avm_byteenable, 4'hF);
      chk("rst_clken", bus.avm_clken, 1'b1);
`ifdef MEM_MASTER_COMPARE_EN
      chk("rst_mcnt", bus.mismatch_cnt, 14'h0);
      chk("rst_fbv", bus.first_bad_valid, 1'b0);
`endif
      reset = 1'b0;
      @(negedge clk); #1;

      run_cmd(1'b1, 0, 4, 32'hA5A50000, 1'b1);
      run_cmd(1'b0, 0, 4, 32'hA5A50000, 1'b1);
      chk("plan_sum", bus.result_sum, 32'h96940006);
      run_cmd(1'b1, 4990, 10, 32'hFFFFFFFF, 1'b1);
      chk("plan_last_addr", aq[aq.size()-1], 13'd4999);
      chk("plan_wrap_data", dq[1], 32'h0);
      run_cmd(1'b0, 4990, 10, 32'hFFFFFFFF, 1'b1);
      run_cmd(1'b1, 4995, 6, 32'h12345678, 1'b0);
      run_cmd(1'b0, 4995, 6, 32'h12345678, 1'b0);
      run_cmd(1'b0, 0, 0, 32'h0, 1'b0);
      run_cmd(1'b1, 10, 0, 32'hDEADBEEF, 1'b1);

      // reset in the middle of an 8-word fill
      p = $urandom;
      accept_cmd(1'b1, 100, 8, p, 1'b1, acc);
      k = 0;
      while (cs_cnt < 3 && k < 30) begin @(negedge clk); #1; k++; end
      chk("mid_rst_writes_before", cs_cnt, 3);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("mid_rst_cs", bus.avm_chipselect, 1'b0);
      chk("mid_rst_write", bus.avm_write, 1'b0);
      chk("mid_rst_ready", bus.cmd_ready, 1'b1);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_done", bus.done, 1'b0);
      reset = 1'b0;
      repeat (4) begin @(negedge clk); #1; end
      mon_en = 1'b0;
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_writes_total", cs_cnt, 3);
      for (int i = 0; i < 3; i++) ref_mem[100 + i] = p + 32'(i);
      run_cmd(1'b0, 100, 8, p, 1'b1);

      for (int n = 0; n < 24; n++) begin
         sel = $urandom_range(0, 9);
         len = (sel == 0) ? 0 : $urandom_range(1, 40);
         if (sel == 1) addr = DEPTH - len + $urandom_range(1, 5);
         else addr = $urandom_range(0, DEPTH - len);
         run_cmd(1'($urandom_range(0, 1)), addr, len, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
